// File: rtl/alu_sequencer.sv
// alu_sequencer: multi-cycle command sequencer driving an external n-bit ALU from a small register file
module alu_sequencer #(
  parameter int N = 4,
  parameter int NREG = 4,
  localparam int AW = $clog2(NREG)
) (
  input  logic          clk,
  input  logic          rst_n,
  input  logic          cmd_valid,
  output logic          cmd_ready,
  input  logic [3:0]    cmd_op,
  input  logic [AW-1:0] cmd_rd,
  input  logic [AW-1:0] cmd_ra,
  input  logic [AW-1:0] cmd_rb,
  input  logic          cmd_fin,
  input  logic [N-1:0]  cmd_imm,
  output logic          rsp_valid,
  input  logic          rsp_ready,
  output logic [N-1:0]  rsp_result,
  output logic          rsp_c,
  output logic          rsp_z,
  output logic          rsp_err,
  output logic [N-1:0]  alu_a,
  output logic [N-1:0]  alu_b,
  output logic          alu_flag_in,
  output logic [3:0]    alu_control,
  input  logic [N-1:0]  alu_result,
  input  logic          alu_c,
  input  logic          alu_z
);
  localparam int CW = $clog2(N + 1);
  localparam logic [3:0] OP_ADD = 4'h2;
  localparam logic [3:0] OP_SUB = 4'h6;
  localparam logic [3:0] OP_XOR = 4'h7;
  localparam logic [3:0] OP_SL  = 4'h8;
  localparam logic [3:0] OP_SR  = 4'h9;
  localparam logic [3:0] OP_LDI = 4'hA;
  typedef enum logic [1:0] {S_IDLE, S_EXEC, S_SHIFT, S_RESP} state_t;
  state_t r_state, w_next;
  logic [N-1:0]  r_rf [NREG];
  logic [AW-1:0] r_rd;
  logic [N-1:0]  r_imm;
  logic [CW-1:0] r_cnt;
  logic [N-1:0]  r_res;
  logic          r_c, r_z, r_err, r_rsp_vld;
  logic [N-1:0]  r_alu_a, r_alu_b;
  logic          r_alu_fin;
  logic [3:0]    r_alu_ctl;
  logic          w_accept, w_rsp_done, w_shift, w_illegal, w_shout, w_exec_we, w_exec_c, w_exec_z;
  logic [CW-1:0] w_k;
  logic [N-1:0]  w_exec_res;
  // The ALU operand/control registers double as the captured command: alu_a is opA, later the shift work value
  assign alu_a       = r_alu_a;
  assign alu_b       = r_alu_b;
  assign alu_flag_in = r_alu_fin;
  assign alu_control = r_alu_ctl;
  assign rsp_result  = r_res;
  assign rsp_c       = r_c;
  assign rsp_z       = r_z;
  assign rsp_err     = r_err;
  assign w_accept    = cmd_valid & cmd_ready;
  assign w_rsp_done  = r_rsp_vld & rsp_ready;
  assign w_shift     = (r_alu_ctl == OP_SL) | (r_alu_ctl == OP_SR);
  assign w_illegal   = r_alu_ctl > OP_LDI;
  assign w_k         = (r_alu_b >= N'(N)) ? CW'(N) : r_alu_b[CW-1:0];
  assign w_shout     = (r_alu_ctl == OP_SL) ? r_alu_a[N-1] : r_alu_a[0];
  assign w_exec_res  = w_illegal ? '0 : (r_alu_ctl == OP_LDI) ? r_imm : w_shift ? r_alu_a : alu_result;
  assign w_exec_c    = ((r_alu_ctl == OP_ADD) | (r_alu_ctl == OP_SUB)) & alu_c;
  assign w_exec_z    = w_illegal ? 1'b0 : (r_alu_ctl <= OP_XOR) ? alu_z : ~|w_exec_res;
  assign w_exec_we   = ~w_illegal & ~(w_shift & (w_k != '0));
  // State register
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) r_state <= S_IDLE;
    else r_state <= w_next;
  end
  // Next-state: a zero-length shift skips SHIFT entirely
  always_comb begin
    w_next = r_state;
    case (r_state)
      S_IDLE:  w_next = w_accept ? S_EXEC : S_IDLE;
      S_EXEC:  w_next = (w_shift && w_k != '0) ? S_SHIFT : S_RESP;
      S_SHIFT: w_next = (r_cnt == CW'(1)) ? S_RESP : S_SHIFT;
      S_RESP:  w_next = w_rsp_done ? S_IDLE : S_RESP;
      default: w_next = S_IDLE;
    endcase
  end
  // Handshake outputs
  always_comb begin
    cmd_ready = r_state == S_IDLE;
    rsp_valid = r_rsp_vld;
  end
  // Datapath: operand capture, execute/shift steps, writeback and response registers
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < NREG; i++) r_rf[i] <= '0;
      r_rd      <= '0;
      r_imm     <= '0;
      r_cnt     <= '0;
      r_res     <= '0;
      r_c       <= 1'b0;
      r_z       <= 1'b0;
      r_err     <= 1'b0;
      r_rsp_vld <= 1'b0;
      r_alu_a   <= '0;
      r_alu_b   <= '0;
      r_alu_fin <= 1'b0;
      r_alu_ctl <= '0;
    end else begin
      r_rsp_vld <= (r_state == S_RESP) & ~w_rsp_done;
      case (r_state)
        S_IDLE: if (w_accept) begin
          r_rd      <= cmd_rd;
          r_imm     <= cmd_imm;
          r_alu_a   <= r_rf[cmd_ra];
          r_alu_b   <= r_rf[cmd_rb];
          r_alu_ctl <= cmd_op;
          r_alu_fin <= cmd_fin;
        end
        S_EXEC: begin
          r_res <= w_exec_res;
          r_c   <= w_exec_c;
          r_z   <= w_exec_z;
          r_err <= w_illegal;
          if (w_exec_we) r_rf[r_rd] <= w_exec_res;
          if (w_shift && w_k != '0) begin
            r_cnt   <= w_k;
            r_alu_b <= N'(1);
          end
        end
        S_SHIFT: begin
          r_alu_a <= alu_result;
          r_c     <= w_shout;
          r_cnt   <= r_cnt - CW'(1);
          if (r_cnt == CW'(1)) begin
            r_res      <= alu_result;
            r_z        <= ~|alu_result;
            r_rf[r_rd] <= alu_result;
          end
        end
        default: ;
      endcase
    end
  end
endmodule
